// File: rtl/opb_register_ppc2simulink_pkg.sv
// Shared definitions for OPB slave register blocks.
// Holds the register offsets, the ack FSM state encoding, the latched request
// payload, the conversion between OPB [0:31] and user [31:0] bit ordering,
// and the byte-enable merge.
package opb_reg_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned OFS_W  = 6;
  localparam int unsigned CNT_W  = 16;

  localparam logic [OFS_W-1:0] OFS_DATA   = 6'd0;
  localparam logic [OFS_W-1:0] OFS_WCOUNT = 6'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_GAP  = 2'd2
  } ack_state_e;

  // One accepted OPB beat, already converted to user bit ordering.
  typedef struct packed {
    logic [OFS_W-1:0]  ofs;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;     // be[3] is OPB_BE[0] (user bits 31:24)
    logic              rnw;
  } opb_req_t;

  // OPB bit 0 is the MSB; it lands on user bit 31.
  function automatic logic [31:0] opb_to_user(input logic [0:31] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = v[i];
    return r;
  endfunction

  function automatic logic [0:31] user_to_opb(input logic [31:0] v);
    logic [0:31] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Replace only the enabled bytes of old_v with new_v.
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/opb_register_ppc2simulink_if.sv
// OPB slave bus bundle.
// master: drives OPB_* request signals; slave: drives Sl_* response signals.
// Vectors keep the OPB big-endian numbering (bit 0 = MSB).
interface opb_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_register_ppc2simulink_ack_fsm.sv
// Generic OPB slave sequencer: address window decode, request latch and the
// IDLE -> ACK -> GAP handshake.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   abus, wdata, be,  request fields in user bit ordering
//   rnw, select
//   accept_c          hit sampled in IDLE this cycle (combinational)
//   req_c             request decoded from the live bus (combinational)
//   req_q             request latched on accept
//   ack_q             registered transfer acknowledge (high in ACK)
//   commit_c          ACK cycle of a write; commit at the end of this cycle
module opb_slave_ack_fsm
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'hFFFF_FFFF,
  parameter logic [31:0] C_HIGHADDR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         abus,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [BE_W-1:0]     be,
  input  logic                rnw,
  input  logic                select,
  output logic                accept_c,
  output opb_req_t            req_c,
  output opb_req_t            req_q,
  output logic                ack_q,
  output logic                commit_c
);

  ack_state_e state_q, state_d;
  opb_req_t   req_d;
  logic       ack_d;
  logic       hit_c;
  logic [31:0] rel_addr_c;

  // Window decode and offset extraction from the live bus.
  always_comb begin
    rel_addr_c  = abus - C_BASEADDR;
    hit_c       = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
    req_c.ofs   = rel_addr_c[7:2];
    req_c.wdata = wdata;
    req_c.be    = be;
    req_c.rnw   = rnw;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      req_q   <= req_d;
    end
  end

  // Next-state logic; GAP ignores select so a held select re-hits in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hit_c) state_d = ST_ACK;
      ST_ACK:  state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: latch on accept, ack follows the ACK state.
  always_comb begin
    accept_c = (state_q == ST_IDLE) && hit_c;
    req_d    = req_q;
    if (accept_c) req_d = req_c;
    ack_d    = (state_d == ST_ACK);
    commit_c = (state_q == ST_ACK) && !req_q.rnw;
  end

endmodule

// File: rtl/opb_register_ppc2simulink.sv
// PPC-writable control register on OPB.
// Offset 0x00: data register (byte-enable writes, readable), with a one-cycle
// user_data_valid strobe per effective write. Offset 0x04: read-only 16-bit
// count of effective writes. Other offsets read 0 and ignore writes.
// Ports:
//   OPB_Clk, OPB_Rst  clock, synchronous active-high reset
//   bus               OPB slave port (request in, Sl_* response out)
//   user_data_out     register contents, bit 31 = OPB bit 0
//   user_data_valid   one-cycle strobe after an effective write to 0x00
module opb_register_ppc2simulink
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR    = 32'hFFFF_FFFF,
  parameter logic [31:0] C_HIGHADDR    = 32'h0000_0000,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter string       C_FAMILY      = "virtex6",
  parameter logic [31:0] C_RESET_VALUE = 32'h0000_0000
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst,
  opb_if.slave        bus,
  output logic [31:0] user_data_out,
  output logic        user_data_valid
);

  logic              accept_c;
  logic              commit_c;
  logic              ack_q;
  opb_req_t          req_c;
  opb_req_t          req_q;

  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  wcount_q, wcount_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] sl_dbus_q, sl_dbus_d;

  opb_slave_ack_fsm #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR)
  ) u_ack_fsm (
    .clk      (OPB_Clk),
    .rst      (OPB_Rst),
    .abus     (opb_to_user(bus.OPB_ABus)),
    .wdata    (opb_to_user(bus.OPB_DBus)),
    .be       ({bus.OPB_BE[0], bus.OPB_BE[1], bus.OPB_BE[2], bus.OPB_BE[3]}),
    .rnw      (bus.OPB_RNW),
    .select   (bus.OPB_select),
    .accept_c (accept_c),
    .req_c    (req_c),
    .req_q    (req_q),
    .ack_q    (ack_q),
    .commit_c (commit_c)
  );

  // Readback is captured on accept so it reflects state at the hit edge;
  // the write commit happens at the end of ACK.
  always_comb begin
    data_d    = data_q;
    wcount_d  = wcount_q;
    valid_d   = 1'b0;
    sl_dbus_d = '0;
    if (accept_c && req_c.rnw) begin
      case (req_c.ofs)
        OFS_DATA:   sl_dbus_d = data_q;
        OFS_WCOUNT: sl_dbus_d = {16'd0, wcount_q};
        default:    sl_dbus_d = '0;
      endcase
    end
    if (commit_c && (req_q.ofs == OFS_DATA) && (req_q.be != 4'b0000)) begin
      data_d   = be_merge(data_q, req_q.wdata, req_q.be);
      wcount_d = wcount_q + 16'd1;
      valid_d  = 1'b1;
    end
  end

  // Register state; reset drops any write still sitting in ACK.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      data_q    <= C_RESET_VALUE;
      wcount_q  <= '0;
      valid_q   <= 1'b0;
      sl_dbus_q <= '0;
    end else begin
      data_q    <= data_d;
      wcount_q  <= wcount_d;
      valid_q   <= valid_d;
      sl_dbus_q <= sl_dbus_d;
    end
  end

  assign bus.Sl_DBus      = user_to_opb(sl_dbus_q);
  assign bus.Sl_xferAck   = ack_q;
  assign bus.Sl_errAck    = 1'b0;
  assign bus.Sl_retry     = 1'b0;
  assign bus.Sl_toutSup   = 1'b0;
  assign user_data_out    = data_q;
  assign user_data_valid  = valid_q;

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// Directed bench for opb_register_ppc2simulink.
module tb_opb_register_ppc2simulink;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] HIGH = 32'h8000_00FF;
  localparam logic [31:0] RV   = 32'h5A5A_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] udo;
  logic        uv;
  int          total = 0;
  int          bad   = 0;

  opb_if bus();

  opb_register_ppc2simulink #(
    .C_BASEADDR    (BASE),
    .C_HIGHADDR    (HIGH),
    .C_OPB_AWIDTH  (32),
    .C_OPB_DWIDTH  (32),
    .C_FAMILY      ("virtex6"),
    .C_RESET_VALUE (RV)
  ) dut (
    .OPB_Clk         (clk),
    .OPB_Rst         (rst),
    .bus             (bus.slave),
    .user_data_out   (udo),
    .user_data_valid (uv)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be, input logic rnw);
    bus.OPB_ABus   = addr;
    bus.OPB_DBus   = data;
    bus.OPB_BE     = be;
    bus.OPB_RNW    = rnw;
    bus.OPB_select = 1'b1;
  endtask

  task automatic release_bus();
    bus.OPB_select = 1'b0;
    bus.OPB_ABus   = '0;
    bus.OPB_DBus   = '0;
    bus.OPB_BE     = '0;
    bus.OPB_RNW    = 1'b0;
  endtask

  // Read: ack and data in N+1, both gone in N+2, back to IDLE after.
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    drive(addr, 32'h0, 4'b1111, 1'b1);
    step();
    check({tag, "_ack"}, 32'(bus.Sl_xferAck), 32'd1);
    check({tag, "_data"}, bus.Sl_DBus, exp);
    release_bus();
    step();
    check({tag, "_ack_gap"}, 32'(bus.Sl_xferAck), 32'd0);
    check({tag, "_dbus_gap"}, bus.Sl_DBus, 32'h0);
    step();
  endtask

  // Write: ack in N+1, new data and strobe in N+2, strobe gone in N+3.
  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input logic exp_valid, input logic [31:0] exp_out);
    drive(addr, data, be, 1'b0);
    step();
    check({tag, "_ack"}, 32'(bus.Sl_xferAck), 32'd1);
    check({tag, "_dbus"}, bus.Sl_DBus, 32'h0);
    release_bus();
    step();
    check({tag, "_valid"}, 32'(uv), 32'(exp_valid));
    check({tag, "_out"}, udo, exp_out);
    step();
    check({tag, "_valid_drop"}, 32'(uv), 32'd0);
  endtask

  // Out-of-window access: no ack and a quiet data bus for several cycles.
  task automatic do_miss(input string tag, input logic [31:0] addr, input logic rnw);
    drive(addr, 32'hFFFF_FFFF, 4'b1111, rnw);
    for (int i = 0; i < 3; i++) begin
      step();
      check({tag, "_noack"}, 32'(bus.Sl_xferAck), 32'd0);
      check({tag, "_dbus"}, bus.Sl_DBus, 32'h0);
    end
    release_bus();
    step();
  endtask

  initial begin
    rst = 1'b1;
    bus.OPB_seqAddr = 1'b0;
    release_bus();
    step(); step(); step();
    rst = 1'b0;
    step();

    check("rst_ack",   32'(bus.Sl_xferAck), 32'd0);
    check("rst_dbus",  bus.Sl_DBus, 32'h0);
    check("rst_valid", 32'(uv), 32'd0);
    check("rst_out",   udo, RV);
    check("rst_err",   32'({bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}), 32'd0);

    do_read("rd_data_rst", BASE, RV);
    do_read("rd_cnt_rst", BASE + 32'h4, 32'h0);

    do_write("wr_full", BASE, 32'hDEAD_BEEF, 4'b1111, 1'b1, 32'hDEAD_BEEF);
    do_read("rd_cnt_1", BASE + 32'h4, 32'h1);
    do_read("rd_data_1", BASE, 32'hDEAD_BEEF);

    // OPB_BE[1] covers DBus[8:15] = 0x34, landing on user bits 23:16.
    do_write("wr_be0100", BASE, 32'h1234_5678, 4'b0100, 1'b1, 32'hDE34_BEEF);
    do_read("rd_cnt_2", BASE + 32'h4, 32'h2);

    do_write("wr_be0000", BASE, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'hDE34_BEEF);
    do_read("rd_cnt_be0", BASE + 32'h4, 32'h2);

    do_write("wr_cnt_ro", BASE + 32'h4, 32'h0000_0055, 4'b1111, 1'b0, 32'hDE34_BEEF);
    do_write("wr_ofs80", BASE + 32'h80, 32'h0BAD_F00D, 4'b1111, 1'b0, 32'hDE34_BEEF);
    do_read("rd_ofs80", BASE + 32'h80, 32'h0);
    do_read("rd_top", BASE + 32'hFC, 32'h0);
    do_read("rd_cnt_ro", BASE + 32'h4, 32'h2);

    do_miss("miss_lo_rd", BASE - 32'h4, 1'b1);
    do_miss("miss_lo_wr", BASE - 32'h4, 1'b0);
    do_miss("miss_hi_rd", HIGH + 32'h1, 1'b1);
    do_read("rd_data_miss", BASE, 32'hDE34_BEEF);

    // Select held: accepts are spaced three cycles apart (ACK, GAP, IDLE).
    drive(BASE, 32'h0, 4'b1111, 1'b1);
    step();
    check("b2b_ack0", 32'(bus.Sl_xferAck), 32'd1);
    step();
    check("b2b_gap",  32'(bus.Sl_xferAck), 32'd0);
    step();
    check("b2b_idle", 32'(bus.Sl_xferAck), 32'd0);
    step();
    check("b2b_ack1", 32'(bus.Sl_xferAck), 32'd1);
    check("b2b_data", bus.Sl_DBus, 32'hDE34_BEEF);
    release_bus();
    step(); step();

    // Preload the counter to its top value, then wrap with one write.
    @(negedge clk);
    force dut.wcount_q = 16'hFFFF;
    @(negedge clk);
    release dut.wcount_q;
    step();
    do_read("rd_cnt_ffff", BASE + 32'h4, 32'h0000_FFFF);
    do_write("wr_wrap", BASE, 32'h0102_0304, 4'b1111, 1'b1, 32'h0102_0304);
    do_read("rd_cnt_wrap", BASE + 32'h4, 32'h0);

    // Reset during the ACK of a write: the write and its strobe are lost.
    do_write("wr_pre", BASE, 32'h1111_1111, 4'b1111, 1'b1, 32'h1111_1111);
    drive(BASE, 32'hAAAA_AAAA, 4'b1111, 1'b0);
    step();
    check("rstack_ack", 32'(bus.Sl_xferAck), 32'd1);
    rst = 1'b1;
    release_bus();
    step();
    rst = 1'b0;
    check("rstack_ack_off", 32'(bus.Sl_xferAck), 32'd0);
    check("rstack_valid", 32'(uv), 32'd0);
    check("rstack_out", udo, RV);
    step();
    check("rstack_valid2", 32'(uv), 32'd0);
    check("rstack_out2", udo, RV);
    do_read("rd_cnt_rst2", BASE + 32'h4, 32'h0);
    do_write("wr_after_rst", BASE, 32'hCAFE_0000, 4'b1100, 1'b1, 32'hCAFE_0001);

    // Reset coinciding with a hit: no ack follows.
    rst = 1'b1;
    drive(BASE, 32'h0, 4'b1111, 1'b1);
    step();
    check("rsthit_ack", 32'(bus.Sl_xferAck), 32'd0);
    check("rsthit_dbus", bus.Sl_DBus, 32'h0);
    rst = 1'b0;
    release_bus();
    step();
    check("rsthit_ack2", 32'(bus.Sl_xferAck), 32'd0);
    do_read("rd_final", BASE, RV);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
